// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bpsk_pkg;

    localparam int PHASE_W   = 30;
    localparam int OUT_W     = 8;
    localparam int LUT_IDX_W = 8;

    localparam logic [PHASE_W-1:0] FREQ_DEFAULT = 30'h1000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        TAIL     = 2'd3
    } state_t;

endpackage

// File: rtl/bpsk_sine_lut.sv
// Registered quarter-wave sine: 8-bit phase in, signed 8-bit sample out (+-127).
// Latency: 1 clock.
// Backpressure: none, free-running one sample per clock.
module bpsk_sine_lut
    import bpsk_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LUT_IDX_W-1:0]  phase,
    output logic signed [7:0]     sample
);

    // round(127*sin(2*pi*k/256)), k = 0..63
    localparam logic [6:0] QTAB [0:63] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
    };

    logic [1:0] quad;
    logic [5:0] k;
    logic [5:0] k_mirror;
    logic [6:0] mag;

    // Fold the phase into the first quadrant; odd quadrants read the table
    // backwards, and the peak (index 64) lies just outside the table.
    always_comb begin
        quad     = phase[7:6];
        k        = phase[5:0];
        k_mirror = 6'd0 - k;
        mag      = QTAB[k];
        if (quad[0]) begin
            mag = (k == 6'd0) ? 7'd127 : QTAB[k_mirror];
        end
    end

    // Second half of the cycle is the negated first half.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= '0;
        end else begin
            sample <= quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        end
    end

endmodule

// File: rtl/bpsk_tx.sv
// BPSK burst transmitter: NCO carrier, preamble / data / tail framing, sign flip per data bit.
// Latency: dout/dout_valid/sym_strobe lag phase and state by 2 clocks.
// Backpressure: pulls one bit per symbol via bit_valid/bit_ready; a missing bit ends the burst.
// Option: define BPSK_TX_DIFF_EN for differential encoding (s_k = d_k ^ s_{k-1}).
module bpsk_tx
    import bpsk_pkg::*;
#(
    parameter int                        PHASE_W      = bpsk_pkg::PHASE_W,
    parameter int                        OUT_W        = bpsk_pkg::OUT_W,
    parameter int                        SPS          = 64,
    parameter int                        PREAMBLE_LEN = 32,
    parameter int                        TAIL_LEN     = 8,
    parameter logic [PHASE_W-1:0]        FREQ_DEFAULT = bpsk_pkg::FREQ_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freq_we,
    input  logic [PHASE_W-1:0]       freq_word,
    input  logic                     start,
    input  logic                     bit_in,
    input  logic                     bit_last,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic                     busy,
    output logic                     underrun,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     dout_valid,
    output logic                     sym_strobe
);

    localparam int CNT_W     = $clog2(SPS);
    localparam int SYM_MAX   = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
    localparam int SYM_CNT_W = $clog2(SYM_MAX + 1);

    state_t                 state;
    logic [PHASE_W-1:0]     freq;
    logic [PHASE_W-1:0]     phase;
    logic [CNT_W-1:0]       cnt;
    logic [SYM_CNT_W-1:0]   sym_cnt;
    logic                   sym;        // symbol value currently on air
    logic                   last_seen;  // bit_last already accepted
    logic                   sym_end;
    logic                   enc_bit;
    logic                   underrun_q;

    logic                   s1;
    logic                   v1;
    logic                   st1;
    logic signed [7:0]      lut_q;

    assign sym_end = (cnt == CNT_W'(SPS - 1));

    // A bit is pulled on the last sample of every data symbol and of the
    // final preamble symbol, unless the burst's last bit is already in.
    assign bit_ready = sym_end &&
                       (((state == DATA) && !last_seen) ||
                        ((state == PREAMBLE) && (sym_cnt == SYM_CNT_W'(PREAMBLE_LEN - 1))));

    assign busy     = (state != IDLE);
    assign underrun = underrun_q;

`ifdef BPSK_TX_DIFF_EN
    assign enc_bit = bit_in ^ sym;
`else
    assign enc_bit = bit_in;
`endif

    // Framing FSM with NCO, symbol timing and bit fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            freq       <= FREQ_DEFAULT;
            phase      <= '0;
            cnt        <= '0;
            sym_cnt    <= '0;
            sym        <= 1'b0;
            last_seen  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (freq_we) begin
                freq <= freq_word;
            end
            underrun_q <= bit_ready && !bit_valid;

            if (state == IDLE) begin
                phase     <= '0;
                cnt       <= '0;
                sym_cnt   <= '0;
                sym       <= 1'b0;
                last_seen <= 1'b0;
                if (start) begin
                    state <= PREAMBLE;
                end
            end else begin
                phase <= phase + freq;
                cnt   <= sym_end ? '0 : cnt + 1'b1;
                if (sym_end) begin
                    sym_cnt <= sym_cnt + 1'b1;
                    case (state)
                        PREAMBLE: begin
                            if (sym_cnt == SYM_CNT_W'(PREAMBLE_LEN - 1)) begin
                                sym_cnt <= '0;
                                if (bit_valid) begin
                                    state     <= DATA;
                                    sym       <= enc_bit;
                                    last_seen <= bit_last;
                                end else begin
                                    state <= TAIL;
                                end
                            end
                        end
                        DATA: begin
                            if (last_seen || !bit_valid) begin
                                state   <= TAIL;
                                sym     <= 1'b0;
                                sym_cnt <= '0;
                            end else begin
                                sym       <= enc_bit;
                                last_seen <= bit_last;
                            end
                        end
                        default: begin
                            if (sym_cnt == SYM_CNT_W'(TAIL_LEN - 1)) begin
                                state <= IDLE;
                                phase <= '0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    bpsk_sine_lut u_lut (
        .clk    (clk),
        .rst    (rst),
        .phase  (phase[PHASE_W-1 -: LUT_IDX_W]),
        .sample (lut_q)
    );

    // Stage 1: carry sign, valid and strobe alongside the LUT register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            v1  <= 1'b0;
            st1 <= 1'b0;
        end else begin
            s1  <= sym;
            v1  <= (state != IDLE);
            st1 <= (state != IDLE) && (cnt == '0);
        end
    end

    // Stage 2: apply the symbol sign; table is symmetric so negation is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sym_strobe <= 1'b0;
        end else begin
            dout       <= s1 ? -lut_q : lut_q;
            dout_valid <= v1;
            sym_strobe <= st1;
        end
    end

endmodule

// File: tb/tb_bpsk_tx.sv
// Directed bench for bpsk_tx: reset, full bursts, underrun, retune and mid-burst reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_bpsk_tx;

    logic               clk = 1'b0;
    logic               rst;
    logic               freq_we;
    logic [29:0]        freq_word;
    logic               start;
    logic               bit_in;
    logic               bit_last;
    logic               bit_valid;
    logic               bit_ready;
    logic               busy;
    logic               underrun;
    logic signed [7:0]  dout;
    logic               dout_valid;
    logic               sym_strobe;

    int tests = 0;
    int fails = 0;

    bpsk_tx dut (
        .clk        (clk),
        .rst        (rst),
        .freq_we    (freq_we),
        .freq_word  (freq_word),
        .start      (start),
        .bit_in     (bit_in),
        .bit_last   (bit_last),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .busy       (busy),
        .underrun   (underrun),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sym_strobe (sym_strobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one burst from start to idle, checking every valid sample against
    // the fs/4 carrier pattern with the expected per-symbol sign.
    task automatic run_burst(input string tag, input int nfeed, input logic [3:0] bits,
                             input logic with_last, input int nsym_data, input logic [3:0] exp_s,
                             input int exp_ready, input int exp_under);
        int pat [4] = '{0, 127, 0, -127};
        int cyc = 0;
        int nvalid = 0;
        int bidx = 0;
        int nready = 0;
        int nunder = 0;
        int ready_cyc = -1;
        int under_cyc = -1;
        int first_valid = -1;
        int busy_fall = -1;
        int j;
        int base;
        int expv;
        logic s;
        logic done = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < 5000) begin
            if (bidx < nfeed) begin
                bit_valid = 1'b1;
                bit_in    = bits[bidx];
                bit_last  = with_last && (bidx == nfeed - 1);
            end else begin
                bit_valid = 1'b0;
                bit_in    = 1'b0;
                bit_last  = 1'b0;
            end
            if (bit_ready) begin
                nready++;
                ready_cyc = cyc;
                if (bit_valid) bidx++;
            end
            if (underrun) begin
                nunder++;
                under_cyc = cyc;
            end
            if (!busy && busy_fall < 0) busy_fall = cyc;
            if (dout_valid) begin
                if (first_valid < 0) first_valid = cyc;
                j    = nvalid / 64;
                s    = (j >= 32 && j < 32 + nsym_data) ? exp_s[j - 32] : 1'b0;
                base = pat[nvalid % 4];
                expv = s ? -base : base;
                chk({tag, "_dout"}, dout, expv);
                chk({tag, "_strobe"}, sym_strobe, (nvalid % 64) == 0);
                nvalid++;
            end
            if (!busy && !dout_valid && cyc > 2) begin
                done = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        bit_valid = 1'b0;
        bit_last  = 1'b0;
        bit_in    = 1'b0;
        chk({tag, "_finished"}, done, 1);
        chk({tag, "_first_valid_cyc"}, first_valid, 2);
        chk({tag, "_nsamples"}, nvalid, (32 + nsym_data + 8) * 64);
        chk({tag, "_nready"}, nready, exp_ready);
        chk({tag, "_nunderrun"}, nunder, exp_under);
        chk({tag, "_valid_fall"}, cyc, busy_fall + 2);
        if (exp_under > 0) chk({tag, "_underrun_at"}, under_cyc, ready_cyc + 1);
    endtask

    initial begin
        int seq8 [8] = '{0, 90, 127, 90, 0, -90, -127, -90};
        logic seen;

        rst = 1'b1; freq_we = 1'b0; freq_word = '0; start = 1'b0;
        bit_in = 1'b0; bit_last = 1'b0; bit_valid = 1'b0;
        tick(); tick(); tick();
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_sym_strobe", sym_strobe, 0);
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (6) tick();
        chk("idle_dout_valid", dout_valid, 0);
        chk("idle_busy", busy, 0);

`ifdef BPSK_TX_DIFF_EN
        run_burst("diff", 3, 4'b0011, 1'b1, 3, 4'b0001, 3, 0);
        run_burst("under", 2, 4'b0011, 1'b0, 2, 4'b0001, 3, 1);
`else
        run_burst("plain", 3, 4'b0101, 1'b1, 3, 4'b0101, 3, 0);
        run_burst("under", 2, 4'b0011, 1'b0, 2, 4'b0011, 3, 1);
`endif

        // Retune to fs/8 during the preamble; the write lands on the 8th edge
        // after start, where the accumulator has wrapped back to zero.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        freq_we = 1'b1;
        freq_word = 30'h0800_0000;
        tick();
        freq_we = 1'b0;
        chk("retune_old0", dout, 0);
        tick();
        chk("retune_old1", dout, -127);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("retune_seq", dout, seq8[i % 8]);
        end

        // Reach DATA, then reset mid-symbol.
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        bit_last  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bit_ready) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_data", seen, 1);
        tick();
        chk("data_busy", busy, 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midrst_dout", dout, 0);
        chk("midrst_dout_valid", dout_valid, 0);
        chk("midrst_sym_strobe", sym_strobe, 0);
        chk("midrst_bit_ready", bit_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_underrun", underrun, 0);
        rst = 1'b0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        repeat (3) tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_dout_valid", dout_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
